// File: rtl/systolic_ctrl_if.sv
// Command, array-control and result signals of the 2x2 systolic array controller.
// slave = controller view; master = command/array side that drives it.
interface systolic_ctrl_if #(
  parameter int RES_WIDTH = 16
);
  logic                        start;
  logic                        cfg_transpose;
  logic                        cfg_activation;
  logic                        busy;
  logic                        clear;
  logic                        data_valid;
  logic [1:0]                  a0_sel;
  logic [1:0]                  a1_sel;
  logic [1:0]                  b0_sel;
  logic [1:0]                  b1_sel;
  logic                        transpose;
  logic                        activation;
  logic signed [RES_WIDTH-1:0] c00_in;
  logic signed [RES_WIDTH-1:0] c01_in;
  logic signed [RES_WIDTH-1:0] c10_in;
  logic signed [RES_WIDTH-1:0] c11_in;
  logic                        res_valid;
  logic                        res_ready;
  logic signed [RES_WIDTH-1:0] res00;
  logic signed [RES_WIDTH-1:0] res01;
  logic signed [RES_WIDTH-1:0] res10;
  logic signed [RES_WIDTH-1:0] res11;

  modport slave (
    input  start, cfg_transpose, cfg_activation, res_ready,
    input  c00_in, c01_in, c10_in, c11_in,
    output busy, clear, data_valid, a0_sel, a1_sel, b0_sel, b1_sel,
    output transpose, activation, res_valid, res00, res01, res10, res11
  );

  modport master (
    output start, cfg_transpose, cfg_activation, res_ready,
    output c00_in, c01_in, c10_in, c11_in,
    input  busy, clear, data_valid, a0_sel, a1_sel, b0_sel, b1_sel,
    input  transpose, activation, res_valid, res00, res01, res10, res11
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for the 2x2 systolic array: clear, skewed feed, drain, result capture.
// state  | meaning
// IDLE   | waiting for start; config latched on acceptance
// CLEAR  | one cycle of accumulator clear
// FEED   | three skewed feed cycles, cnt = k (0..2)
// DRAIN  | pipeline drain, cnt counts down to 0, capture on exit
// RESULT | results held until res_ready
module systolic_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int RES_WIDTH    = 16
) (
  input  logic          clk,
  input  logic          rst,
  systolic_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [1:0] SEL_ZERO   = 2'd2;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       capture;
  logic       busy_d, clear_d, data_valid_d, res_valid_d;
  logic [1:0] a0_sel_d, a1_sel_d;

  // Outputs are registered decodes of the next state so reset forces them all to 0.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    busy_d       = 1'b0;
    clear_d      = 1'b0;
    data_valid_d = 1'b0;
    res_valid_d  = 1'b0;
    a0_sel_d     = SEL_ZERO;
    a1_sel_d     = SEL_ZERO;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = FEED;
        cnt_d   = 4'd0;
      end
      FEED: begin
        if (cnt_q == 4'd2) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd0) begin
          state_d = RESULT;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESULT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    busy_d       = (state_d != IDLE);
    clear_d      = (state_d == CLEAR);
    data_valid_d = (state_d == FEED);
    res_valid_d  = (state_d == RESULT);
    // Row/column 1 lag row/column 0 by one cycle.
    if (state_d == FEED) begin
      a0_sel_d = cnt_d[1:0];
      a1_sel_d = (cnt_d == 4'd0) ? SEL_ZERO : 2'(cnt_d - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      bus.busy       <= 1'b0;
      bus.clear      <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.a0_sel     <= 2'd0;
      bus.a1_sel     <= 2'd0;
      bus.b0_sel     <= 2'd0;
      bus.b1_sel     <= 2'd0;
      bus.transpose  <= 1'b0;
      bus.activation <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res00      <= '0;
      bus.res01      <= '0;
      bus.res10      <= '0;
      bus.res11      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bus.busy       <= busy_d;
      bus.clear      <= clear_d;
      bus.data_valid <= data_valid_d;
      bus.a0_sel     <= a0_sel_d;
      bus.a1_sel     <= a1_sel_d;
      bus.b0_sel     <= a0_sel_d;
      bus.b1_sel     <= a1_sel_d;
      bus.res_valid  <= res_valid_d;
      if (state_q == IDLE && bus.start) begin
        bus.transpose  <= bus.cfg_transpose;
        bus.activation <= bus.cfg_activation;
      end
      if (capture) begin
        bus.res00 <= bus.c00_in;
        bus.res01 <= bus.c01_in;
        bus.res10 <= bus.c10_in;
        bus.res11 <= bus.c11_in;
      end
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a small behavioural 2x2 array behind it.
module tb_systolic_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  systolic_ctrl_if #(.RES_WIDTH(16)) bus ();

  systolic_ctrl #(.DRAIN_CYCLES(2), .RES_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Array model: W row-major, X row-major; PE(i,j) sees a_i delayed j cycles, b_j delayed i.
  logic signed [15:0] w_m [4];
  logic signed [15:0] x_m [4];
  logic signed [15:0] a0v, a1v, b0v, b1v;
  logic signed [15:0] a0d = '0, a1d = '0, b0d = '0, b1d = '0;
  logic signed [15:0] acc00 = '0, acc01 = '0, acc10 = '0, acc11 = '0;

  function automatic logic signed [15:0] relu(input logic act, input logic signed [15:0] v);
    return (act && v < 0) ? 16'sd0 : v;
  endfunction

  function automatic logic signed [15:0] opa(input logic dv, input int i, input logic [1:0] s);
    if (!dv || s == 2'd2) return 16'sd0;
    return w_m[i*2 + int'(s)];
  endfunction

  function automatic logic signed [15:0] opb(input logic dv, input logic tr, input int j,
                                             input logic [1:0] s);
    if (!dv || s == 2'd2) return 16'sd0;
    return tr ? x_m[j*2 + int'(s)] : x_m[int'(s)*2 + j];
  endfunction

  always_comb begin
    a0v = opa(bus.data_valid, 0, bus.a0_sel);
    a1v = opa(bus.data_valid, 1, bus.a1_sel);
    b0v = opb(bus.data_valid, bus.transpose, 0, bus.b0_sel);
    b1v = opb(bus.data_valid, bus.transpose, 1, bus.b1_sel);
  end

  always @(posedge clk) begin
    a0d <= a0v; a1d <= a1v; b0d <= b0v; b1d <= b1v;
    if (bus.clear) begin
      acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
    end else begin
      acc00 <= acc00 + 16'(a0v * b0v);
      acc01 <= acc01 + 16'(a0d * b1v);
      acc10 <= acc10 + 16'(a1v * b0d);
      acc11 <= acc11 + 16'(a1d * b1d);
    end
  end

  assign bus.c00_in = relu(bus.activation, acc00);
  assign bus.c01_in = relu(bus.activation, acc01);
  assign bus.c10_in = relu(bus.activation, acc10);
  assign bus.c11_in = relu(bus.activation, acc11);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w0, w1, w2, w3, x0, x1, x2, x3);
    w_m[0] = w0; w_m[1] = w1; w_m[2] = w2; w_m[3] = w3;
    x_m[0] = x0; x_m[1] = x1; x_m[2] = x2; x_m[3] = x3;
  endtask

  // FEED table: a0/b0 selects and a1/b1 selects for k = 0,1,2.
  logic [1:0] sel0_tab [3] = '{2'd0, 2'd1, 2'd2};
  logic [1:0] sel1_tab [3] = '{2'd2, 2'd0, 2'd1};

  task automatic run_job(input logic tr, input logic act,
                         input logic [15:0] e00, e01, e10, e11, input logic handshake);
    int n;
    bus.cfg_transpose  = tr;
    bus.cfg_activation = act;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.cfg_transpose  = ~tr;
    bus.cfg_activation = ~act;
    n = 1;
    chk("clear_cyc_clear", 16'(bus.clear), 16'd1);
    chk("clear_cyc_dv", 16'(bus.data_valid), 16'd0);
    chk("clear_cyc_a0", 16'(bus.a0_sel), 16'd2);
    chk("clear_cyc_busy", 16'(bus.busy), 16'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      n++;
      chk("feed_clear", 16'(bus.clear), 16'd0);
      chk("feed_dv", 16'(bus.data_valid), 16'd1);
      chk("feed_a0", 16'(bus.a0_sel), 16'(sel0_tab[k]));
      chk("feed_b0", 16'(bus.b0_sel), 16'(sel0_tab[k]));
      chk("feed_a1", 16'(bus.a1_sel), 16'(sel1_tab[k]));
      chk("feed_b1", 16'(bus.b1_sel), 16'(sel1_tab[k]));
    end
    do begin
      tick();
      n++;
      if (!bus.res_valid) begin
        chk("drain_dv", 16'(bus.data_valid), 16'd0);
        chk("drain_b1", 16'(bus.b1_sel), 16'd2);
      end
    end while (!bus.res_valid && n < 40);
    chk("latency", 16'(n), 16'd7);
    chk("res00", bus.res00, e00);
    chk("res01", bus.res01, e01);
    chk("res10", bus.res10, e10);
    chk("res11", bus.res11, e11);
    chk("res_transpose", 16'(bus.transpose), 16'(tr));
    chk("res_activation", 16'(bus.activation), 16'(act));
    chk("res_busy", 16'(bus.busy), 16'd1);
    chk("res_sel", 16'(bus.a0_sel), 16'd2);
    if (handshake) begin
      tick();
      chk("post_valid", 16'(bus.res_valid), 16'd0);
      chk("post_busy", 16'(bus.busy), 16'd0);
      chk("post_res00_held", bus.res00, e00);
      chk("post_transpose_held", 16'(bus.transpose), 16'(tr));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cfg_transpose = 1'b0;
    bus.cfg_activation = 1'b0;
    bus.res_ready = 1'b1;
    load(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    #3;
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_clear", 16'(bus.clear), 16'd0);
    chk("rst_dv", 16'(bus.data_valid), 16'd0);
    chk("rst_a0", 16'(bus.a0_sel), 16'd0);
    chk("rst_b1", 16'(bus.b1_sel), 16'd0);
    chk("rst_valid", 16'(bus.res_valid), 16'd0);
    chk("rst_res00", bus.res00, 16'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("idle_a1", 16'(bus.a1_sel), 16'd2);
    chk("idle_busy", 16'(bus.busy), 16'd0);

    run_job(1'b0, 1'b0, 16'd19, 16'd22, 16'd43, 16'd50, 1'b1);
    run_job(1'b1, 1'b0, 16'd17, 16'd23, 16'd39, 16'd53, 1'b1);
    load(16'hFFFD, 16'd1, 16'd2, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd1);
    run_job(1'b0, 1'b0, 16'hFFFD, 16'd1, 16'd2, 16'hFFFF, 1'b1);
    run_job(1'b0, 1'b1, 16'd0, 16'd1, 16'd2, 16'd0, 1'b1);

    // Stalled consumer with a start pulse that must be ignored.
    load(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    bus.res_ready = 1'b0;
    run_job(1'b0, 1'b0, 16'd19, 16'd22, 16'd43, 16'd50, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 4);
      tick();
      chk("stall_valid", 16'(bus.res_valid), 16'd1);
      chk("stall_busy", 16'(bus.busy), 16'd1);
      chk("stall_res11", bus.res11, 16'd50);
    end
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    chk("release_busy", 16'(bus.busy), 16'd0);
    chk("release_valid", 16'(bus.res_valid), 16'd0);
    tick();
    chk("no_queue_busy", 16'(bus.busy), 16'd0);
    chk("no_queue_clear", 16'(bus.clear), 16'd0);

    // Reset during FEED k=1, then a clean job.
    bus.cfg_transpose = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("midrst_pre_a0", 16'(bus.a0_sel), 16'd1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 16'(bus.busy), 16'd0);
    chk("midrst_dv", 16'(bus.data_valid), 16'd0);
    chk("midrst_a0", 16'(bus.a0_sel), 16'd0);
    chk("midrst_a1", 16'(bus.a1_sel), 16'd0);
    chk("midrst_transpose", 16'(bus.transpose), 16'd0);
    chk("midrst_res00", bus.res00, 16'd0);
    tick();
    rst = 1'b1;
    tick();
    run_job(1'b0, 1'b0, 16'd19, 16'd22, 16'd43, 16'd50, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencing controller for the 2x2 weight-stationary-fed systolic array.
- Accepts a start pulse with per-job config, clears the PE accumulators, and generates the skewed feed schedule (data_valid, a0/a1/b0/b1 selects).
- Waits out the pipeline drain, then captures the four results into holding registers presented with a valid/ready handshake.
- Sits between the top-level command interface and the array instance; the array's memory operands are wired directly and are not touched here.

Parameters:
- DRAIN_CYCLES, 2, cycles waited after last feed cycle before capture; legal range 1..15.
- RES_WIDTH, 16, width of array result inputs and captured result outputs (signed).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  job request, sampled only in IDLE
- cfg_transpose  in  1  transpose mode for the job, latched on accepted start
- cfg_activation  in  1  ReLU enable for the job, latched on accepted start
- busy  out  1  high in every state except IDLE
- clear  out  1  accumulator clear to array
- data_valid  out  1  feed-enable to array
- a0_sel, a1_sel, b0_sel, b1_sel  out  2 each  operand selects to array (2'd2 = zero operand)
- transpose  out  1  latched cfg_transpose
- activation  out  1  latched cfg_activation
- c00_in, c01_in, c10_in, c11_in  in  RES_WIDTH each  signed array outputs
- res_valid  out  1  captured results available
- res_ready  in  1  consumer accepts results
- res00, res01, res10, res11  out  RES_WIDTH each  captured results

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0; all outputs 0, including sel outputs, transpose, activation and res*.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> RESULT -> IDLE.
- IDLE: start=1 -> latch cfg_* into transpose/activation, go CLEAR.
- CLEAR: one cycle, clear=1.
- FEED: exactly 3 cycles, count k=0,1,2; data_valid=1 throughout.
  - k=0: a0_sel=0, a1_sel=2, b0_sel=0, b1_sel=2
  - k=1: a0_sel=1, a1_sel=0, b0_sel=1, b1_sel=0
  - k=2: a0_sel=2, a1_sel=1, b0_sel=2, b1_sel=1
- DRAIN: DRAIN_CYCLES cycles, data_valid=0.
- Last DRAIN cycle: c*_in registered into res* on the exiting edge.
- RESULT: res_valid=1, res* stable; res_ready=1 -> IDLE (res_valid drops next cycle).
- Outside FEED: data_valid=0, all sels=2'd2. clear=0 outside CLEAR.
- All control outputs are Moore decodes of registered state/count; no combinational input-to-output paths.
- Latency: start sampled in cycle T -> clear in T+1, feed in T+2..T+4, res_valid first high in T+5+DRAIN_CYCLES.
- transpose/activation hold their latched values from start acceptance until the next accepted start, so they stay valid through capture and RESULT.
- start while busy (any non-IDLE state, including RESULT): ignored, no queueing.
- res_ready while not in RESULT: ignored.
- Results are held indefinitely while res_ready=0; res* retain their last values after handshake until the next capture.
- Reset mid-job: immediate return to IDLE, outputs zeroed; a new start after release runs a full clean job.

Test Plan:
- W=[1,2,3,4], X=[5,6,7,8], transpose=0, act=0, res_ready=1 -> res00..11 = 19,22,43,50; res_valid first high 7 cycles after start cycle (DRAIN_CYCLES=2).
- Same operands, transpose=1 -> res = 17,23,39,53; transpose output held high through RESULT.
- W=[-3,1,2,-1], X=identity [1,0,0,1]:
  - act=0 -> res = 16'hFFFD, 1, 2, 16'hFFFF
  - act=1 -> res = 0, 1, 2, 0
- Check per-cycle trace of clear, data_valid and the four sel outputs against the FEED table; sels=2 and data_valid=0 in all other states.
- res_ready held 0 for 10 cycles -> res_valid and res* stable; pulse start during the stall -> ignored, busy stays 1; assert res_ready -> IDLE next cycle, busy=0.
- Assert rst during FEED k=1 -> all outputs 0 immediately; after release, start a job with W=[1,2,3,4], X=[5,6,7,8] -> res = 19,22,43,50 (clear proves no stale accumulation).
